// File: rtl/jt1943_romrq_server.sv
// ROM-request responder: round-robin arbitration of four cached ROM clients onto
// a single SDRAM read port. Each grant fetches two 16-bit words and returns 32 bits.
module jt1943_romrq_server #(
    parameter int              AW    = 18,
    parameter int              SW    = 22,
    parameter logic [SW-1:0]   OFFS0 = '0,
    parameter logic [SW-1:0]   OFFS1 = '0,
    parameter logic [SW-1:0]   OFFS2 = '0,
    parameter logic [SW-1:0]   OFFS3 = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cen,
    input  logic [3:0]    i_req,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [AW-1:0] i_addr2,
    input  logic [AW-1:0] i_addr3,
    output logic [3:0]    o_we,
    output logic [31:0]   o_dout,
    output logic          o_sdram_req,
    output logic [SW-1:0] o_sdram_addr,
    input  logic          i_sdram_ack,
    input  logic          i_data_rdy,
    input  logic [15:0]   i_data_read
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT0   = 3'd2,
        WAIT1   = 3'd3,
        DELIVER = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_ptr, w_ptr_nxt;
    logic [1:0]      r_sel, w_sel_nxt;
    logic [AW-3:0]   r_aaddr, w_aaddr_nxt;
    logic [SW-1:0]   r_sdram_addr, w_sdram_addr_nxt;
    logic            r_sdram_req, w_sdram_req_nxt;
    logic [3:0]      r_we, w_we_nxt;
    logic [31:0]     r_dout, w_dout_nxt;

    logic [1:0]      w_grant;
    logic [AW-3:0]   w_aaddr_gnt;
    logic [AW-3:0]   w_aaddr_cur;
    logic            w_match;
    logic [3:0]      w_we_onehot;
    logic            w_unused_ok;

    // First requester at or after the pointer, wrapping mod 4.
    function automatic logic [1:0] f_rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        f_rr_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) f_rr_pick = idx;
        end
    endfunction

    function automatic logic [AW-3:0] f_aaddr(input logic [1:0] sel);
        case (sel)
            2'd0:    f_aaddr = i_addr0[AW-1:2];
            2'd1:    f_aaddr = i_addr1[AW-1:2];
            2'd2:    f_aaddr = i_addr2[AW-1:2];
            default: f_aaddr = i_addr3[AW-1:2];
        endcase
    endfunction

    function automatic logic [SW-1:0] f_offs(input logic [1:0] sel);
        case (sel)
            2'd0:    f_offs = OFFS0;
            2'd1:    f_offs = OFFS1;
            2'd2:    f_offs = OFFS2;
            default: f_offs = OFFS3;
        endcase
    endfunction

    // Byte-address bits [1:0] carry no information for 32-bit aligned fetches.
    assign w_unused_ok = &{1'b0, i_addr0[1:0], i_addr1[1:0], i_addr2[1:0], i_addr3[1:0]};

    assign w_grant     = f_rr_pick(i_req, r_ptr);
    assign w_aaddr_gnt = f_aaddr(w_grant);
    assign w_aaddr_cur = f_aaddr(r_sel);
    assign w_match     = i_req[r_sel] && (w_aaddr_cur == r_aaddr);
    assign w_we_onehot = 4'b0001 << r_sel;

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_sel_nxt        = r_sel;
        w_aaddr_nxt      = r_aaddr;
        w_sdram_addr_nxt = r_sdram_addr;
        w_sdram_req_nxt  = r_sdram_req;
        w_we_nxt         = r_we;
        w_dout_nxt       = r_dout;

        case (r_state)
            IDLE: begin
                w_we_nxt = 4'b0000;
                if (|i_req) begin
                    w_sel_nxt        = w_grant;
                    w_aaddr_nxt      = w_aaddr_gnt;
                    // Two SDRAM words per 32-bit client word; wraps modulo 2^SW.
                    w_sdram_addr_nxt = f_offs(w_grant) + SW'({w_aaddr_gnt, 1'b0});
                    w_sdram_req_nxt  = 1'b1;
                    w_ptr_nxt        = w_grant + 2'd1;
                    w_state_nxt      = REQ;
                end
            end
            REQ: begin
                if (i_sdram_ack) begin
                    w_sdram_req_nxt = 1'b0;
                    if (i_data_rdy) begin
                        w_dout_nxt[15:0] = i_data_read;
                        w_state_nxt      = WAIT1;
                    end else begin
                        w_state_nxt      = WAIT0;
                    end
                end
            end
            WAIT0: begin
                if (i_data_rdy) begin
                    w_dout_nxt[15:0] = i_data_read;
                    w_state_nxt      = WAIT1;
                end
            end
            WAIT1: begin
                if (i_data_rdy) begin
                    w_dout_nxt[31:16] = i_data_read;
                    w_state_nxt       = DELIVER;
                end
            end
            DELIVER: begin
                // A request that moved or vanished since the grant gets nothing.
                if (!w_match) begin
                    w_we_nxt    = 4'b0000;
                    w_state_nxt = IDLE;
                end else if ((|r_we) && i_cen) begin
                    w_we_nxt    = 4'b0000;
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = w_we_onehot;
                end
            end
            default: begin
                w_we_nxt        = 4'b0000;
                w_sdram_req_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= 2'd0;
            r_sel        <= 2'd0;
            r_aaddr      <= '0;
            r_sdram_addr <= '0;
            r_sdram_req  <= 1'b0;
            r_we         <= 4'b0000;
            r_dout       <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_sel        <= w_sel_nxt;
            r_aaddr      <= w_aaddr_nxt;
            r_sdram_addr <= w_sdram_addr_nxt;
            r_sdram_req  <= w_sdram_req_nxt;
            r_we         <= w_we_nxt;
            r_dout       <= w_dout_nxt;
        end
    end

    assign o_we         = r_we;
    assign o_dout       = r_dout;
    assign o_sdram_req  = r_sdram_req;
    assign o_sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jt1943_romrq_server.sv
// Directed bench for jt1943_romrq_server: table of single/contention fetches plus
// hand-written cen-gating, stale-request and reset-abort sequences.
module tb_jt1943_romrq_server;

    localparam int AW = 18;
    localparam int SW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b1;
    logic [3:0]    req = 4'b0000;
    logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0, addr3 = '0;
    logic [3:0]    we;
    logic [31:0]   dout;
    logic          sdram_req;
    logic [SW-1:0] sdram_addr;
    logic          sdram_ack = 1'b0;
    logic          data_rdy = 1'b0;
    logic [15:0]   data_read = 16'h0000;

    int checks = 0;
    int errors = 0;

    jt1943_romrq_server #(
        .AW(AW), .SW(SW),
        .OFFS0(22'h010000), .OFFS1(22'h020000), .OFFS2(22'h030000), .OFFS3(22'h3FFFFF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_req(req),
        .i_addr0(addr0), .i_addr1(addr1), .i_addr2(addr2), .i_addr3(addr3),
        .o_we(we), .o_dout(dout), .o_sdram_req(sdram_req), .o_sdram_addr(sdram_addr),
        .i_sdram_ack(sdram_ack), .i_data_rdy(data_rdy), .i_data_read(data_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_before;
        logic [3:0]    req;
        logic [AW-1:0] a0, a1, a2, a3;
        logic [15:0]   d0, d1;
        logic          same;
        int            ackdly;
        logic [SW-1:0] exp_addr;
        logic [3:0]    exp_we;
        logic [31:0]   exp_dout;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; cen = 1'b1; sdram_ack = 1'b0; data_rdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string name, input logic [SW-1:0] exp);
        for (int n = 0; n < 12 && !sdram_req; n++) tick();
        chk({name, "_req"}, 32'(sdram_req), 32'd1);
        chk({name, "_addr"}, 32'(sdram_addr), 32'(exp));
    endtask

    task automatic send_word(input logic [15:0] d, input logic ack);
        data_rdy = 1'b1; data_read = d; sdram_ack = ack;
        tick();
        data_rdy = 1'b0; sdram_ack = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [SW-1:0] exp, input logic [15:0] d0,
                         input logic [15:0] d1, input logic same, input int ackdly);
        wait_req(name, exp);
        for (int n = 0; n < ackdly; n++) begin
            tick();
            chk({name, "_hold"}, 32'({sdram_req, sdram_addr}), 32'({1'b1, exp}));
        end
        if (same) send_word(d0, 1'b1);
        else begin
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
        end
        chk({name, "_reqdrop"}, 32'(sdram_req), 32'd0);
        if (!same) send_word(d0, 1'b0);
        send_word(d1, 1'b0);
    endtask

    task automatic wait_we(input string name, input logic [3:0] exp_we, input logic [31:0] exp_dout);
        for (int n = 0; n < 12 && we == 4'b0000; n++) tick();
        chk({name, "_we"}, 32'(we), 32'(exp_we));
        chk({name, "_dout"}, dout, exp_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        seen;
        logic [31:0] held;

        vec[0] = '{1'b0, 4'b0001, 18'h00104, 18'h00000, 18'h00000, 18'h00000,
                   16'hBEEF, 16'hDEAD, 1'b0, 0, 22'h010082, 4'b0001, 32'hDEADBEEF};
        vec[1] = '{1'b1, 4'b1111, 18'h00107, 18'h00010, 18'h3FFFC, 18'h00008,
                   16'h1111, 16'h2222, 1'b1, 0, 22'h010082, 4'b0001, 32'h22221111};
        vec[2] = '{1'b0, 4'b1111, 18'h00107, 18'h00010, 18'h3FFFC, 18'h00008,
                   16'h3333, 16'h4444, 1'b0, 2, 22'h020008, 4'b0010, 32'h44443333};
        vec[3] = '{1'b0, 4'b1111, 18'h00107, 18'h00010, 18'h3FFFC, 18'h00008,
                   16'h5555, 16'h6666, 1'b1, 0, 22'h04FFFE, 4'b0100, 32'h66665555};
        vec[4] = '{1'b0, 4'b1111, 18'h00107, 18'h00010, 18'h3FFFC, 18'h00008,
                   16'h7777, 16'h8888, 1'b0, 1, 22'h000003, 4'b1000, 32'h88887777};
        vec[5] = '{1'b0, 4'b1111, 18'h00107, 18'h00010, 18'h3FFFC, 18'h00008,
                   16'h9999, 16'hAAAA, 1'b0, 0, 22'h010082, 4'b0001, 32'hAAAA9999};

        // Reset state
        #2;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_sdram_req", 32'(sdram_req), 32'd0);
        chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single client, then round-robin contention with req held at 4'b1111
        for (int i = 0; i < 6; i++) begin
            if (vec[i].rst_before) do_reset();
            req = vec[i].req;
            addr0 = vec[i].a0; addr1 = vec[i].a1; addr2 = vec[i].a2; addr3 = vec[i].a3;
            fetch($sformatf("v%0d", i), vec[i].exp_addr, vec[i].d0, vec[i].d1,
                  vec[i].same, vec[i].ackdly);
            wait_we($sformatf("v%0d", i), vec[i].exp_we, vec[i].exp_dout);
            tick();
            chk($sformatf("v%0d_wefall", i), 32'(we), 32'd0);
        end

        // cen gating: we holds with stable dout until a cen cycle
        req = 4'b0010; addr1 = 18'h00010; cen = 1'b0;
        fetch("cen", 22'h020008, 16'h0BAD, 16'hF00D, 1'b0, 0);
        wait_we("cen", 4'b0010, 32'hF00D0BAD);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("cen_hold%0d_we", n), 32'(we), 32'h2);
            chk($sformatf("cen_hold%0d_dout", n), dout, 32'hF00D0BAD);
        end
        cen = 1'b1;
        tick();
        chk("cen_wefall", 32'(we), 32'd0);
        req = 4'b0000;

        // Stale request: client 1 address moves during WAIT1
        tick();
        req = 4'b0010; addr1 = 18'h00010;
        wait_req("st", 22'h020008);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        send_word(16'h1234, 1'b0);
        addr1 = 18'h00020;
        send_word(16'h5678, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 12 && !sdram_req; n++) begin
            tick();
            if (we != 4'b0000) seen = 1'b1;
        end
        chk("st_nowe", 32'(seen), 32'd0);
        chk("st_regrant_req", 32'(sdram_req), 32'd1);
        chk("st_regrant_addr", 32'(sdram_addr), 32'h020010);
        send_word(16'h9ABC, 1'b1);
        send_word(16'hDEF0, 1'b0);
        wait_we("st2", 4'b0010, 32'hDEF09ABC);
        tick();
        chk("st2_wefall", 32'(we), 32'd0);
        req = 4'b0000;

        // Reset abort in WAIT0; late data afterwards is ignored
        tick();
        req = 4'b0001; addr0 = 18'h00104;
        wait_req("ab", 22'h010082);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        held = dout;
        rst_n = 1'b0;
        #1;
        chk("ab_dout_before", 32'(held != 32'd0), 32'd1);
        chk("ab_we", 32'(we), 32'd0);
        chk("ab_sdram_req", 32'(sdram_req), 32'd0);
        chk("ab_sdram_addr", 32'(sdram_addr), 32'd0);
        chk("ab_dout", dout, 32'd0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        send_word(16'hABCD, 1'b0);
        send_word(16'h4321, 1'b0);
        tick();
        chk("ab_late_dout", dout, 32'd0);
        chk("ab_late_req", 32'(sdram_req), 32'd0);
        chk("ab_late_we", 32'(we), 32'd0);

        // Normal service resumes after the abort
        req = 4'b0100; addr2 = 18'h3FFFC;
        fetch("post", 22'h04FFFE, 16'hCAFE, 16'hF00D, 1'b1, 0);
        wait_we("post", 4'b0100, 32'hF00DCAFE);
        tick();
        chk("post_wefall", 32'(we), 32'd0);
        req = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt1943_romrq_server.md
Name: jt1943_romrq_server

Overview:
- Responder end of the ROM-request protocol: serves up to four cached ROM clients that each present `req`/`addr_req` and expect a 32-bit `din` plus a `we` strobe.
- Arbitrates the clients round-robin and fetches two consecutive 16-bit SDRAM words per request.
- Assembles the two words into 32 bits and returns them to the granted client, qualified by `cen`.
- Sits between the game's ROM clients (CPU, char, scroll, object) and the shared SDRAM controller.

Parameters:
- AW, 18: client byte-address width.
- SW, 22: SDRAM word-address width.
- OFFS0, 0: SDRAM word offset of client 0's ROM region.
- OFFS1, 0: SDRAM word offset of client 1's ROM region.
- OFFS2, 0: SDRAM word offset of client 2's ROM region.
- OFFS3, 0: SDRAM word offset of client 3's ROM region.

Ports:
- clk  in  1  system clock, only clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  client clock enable; `we` delivery completes only on a `cen` cycle.
- req  in  4  per-client request, bit k = client k.
- addr0..addr3  in  AW each  client byte address, 32-bit aligned (addr[1:0] ignored).
- we  out  4  one-hot data-valid strobe to the granted client.
- dout  out  32  returned data; low SDRAM word in [15:0].
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  SW  SDRAM word address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  one SDRAM read word valid this cycle.
- data_read  in  16  SDRAM read word.

Behaviour:
- Reset (asynchronous, rst_n low):
  - we=0, dout=0, sdram_req=0, sdram_addr=0.
  - State IDLE; round-robin pointer = client 0.
  - Reset mid-transaction aborts it; SDRAM words arriving afterwards are ignored until the next grant.
- State machine: IDLE -> REQ -> WAIT0 -> WAIT1 -> DELIVER -> IDLE.
- IDLE:
  - If any req bit is set, grant the first requesting client starting at the pointer and searching upward mod 4.
  - Latch the client index k and aligned address A = addr_k[AW-1:2].
  - Register sdram_addr = OFFSk + {A,1'b0} (zero-extended to SW, modulo 2^SW).
  - Next cycle: sdram_req=1, state REQ.
  - Pointer becomes k+1 mod 4.
- REQ:
  - Hold sdram_req and sdram_addr stable until sdram_ack=1.
  - On the ack cycle, clear sdram_req next cycle and go to WAIT0.
  - A data_rdy in the same cycle as sdram_ack is accepted as word 0.
- WAIT0: on data_rdy, dout[15:0] <= data_read; go to WAIT1.
- WAIT1: on data_rdy, dout[31:16] <= data_read; go to DELIVER.
- DELIVER:
  - Check the granted client: req_k still 1 and addr_k[AW-1:2]==A.
  - If the check fails (stale request), drop the data: we stays 0, go to IDLE.
  - Otherwise raise we[k] and hold it, with dout stable, until a cycle where cen=1.
  - we[k] falls the cycle after that cen cycle; then IDLE.
  - The check is re-evaluated every DELIVER cycle. If the client's address changes while waiting for cen, withdraw we and go to IDLE without delivering.
- we is never multi-hot. dout changes only in WAIT0/WAIT1.
- A request whose req bit drops during REQ/WAIT still completes the SDRAM burst; the stale check discards it.
- Minimum latency, req seen in IDLE at cycle 0:
  - cycle 1: sdram_req high.
  - Ack at cycle 1, two data_rdy at cycles 1 and 2.
  - DELIVER at cycle 3; we high at cycle 4 if cen=1.
- One outstanding SDRAM request at a time; no pipelining.
- A client whose req persists after service is re-granted only after the pointer passes it (fairness).

Test Plan:
- Single client: req=4'b0001, addr0=18'h00104, OFFS0=22'h10000, cen=1, ack immediate, data 16'hBEEF then 16'hDEAD -> sdram_addr=22'h10082, dout=32'hDEADBEEF, we=4'b0001 for exactly one cycle.
- Contention: req=4'b1111 held continuously -> grants in order 0,1,2,3,0, each separated by a complete fetch, we one-hot each time.
- cen gating: cen high 1-in-4 cycles -> we[k] stays high with dout constant until the first cen=1 cycle, drops the next cycle.
- Stale request: addr1 changes from 18'h00010 to 18'h00020 during WAIT1 -> no we pulse, next IDLE grants the new address.
- Reset abort: rst_n low during WAIT0 -> we=0, sdram_req=0 immediately (async); a late data_rdy after reset release does not alter dout.
- Ack/data same cycle: sdram_ack and data_rdy both high -> that word is stored as dout[15:0].
